// File: rtl/mastermind_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mastermind_pkg
// Purpose  : Shared constants, state encoding and colour-slice helper for the
//            Mastermind scoring datapath.
// Contents : NUM_POS, DEFAULT_COLOR_W, MAX_COLOR_W, VEC_W, CNT_W,
//            state_t {IDLE, EXACT, COLOUR, DONE}, colour_at()
// Revision : 1.0 - initial release
// ============================================================================
package mastermind_pkg;

  localparam int NUM_POS         = 4;
  localparam int DEFAULT_COLOR_W = 3;
  // Upper bound on colour width; the helper works on a vector of this size
  // so it can serve any COLOR_W up to MAX_COLOR_W.
  localparam int MAX_COLOR_W     = 8;
  localparam int VEC_W           = NUM_POS * MAX_COLOR_W;
  // Peg counts range 0..4.
  localparam int CNT_W           = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXACT  = 2'd1,
    COLOUR = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Returns the colour at position idx of a packed code vector. Bits above
  // the caller's colour width belong to the next position and must be
  // masked by the caller.
  function automatic logic [MAX_COLOR_W-1:0] colour_at(
    input logic [VEC_W-1:0] vec,
    input int unsigned      width,
    input logic [1:0]       idx
  );
    logic [VEC_W-1:0] shifted;
    shifted = vec >> (width * idx);
    return shifted[MAX_COLOR_W-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/mastermind_turn_tracker.sv
`default_nettype none
// ============================================================================
// Module   : mastermind_turn_tracker
// Purpose  : Per-game bookkeeping: counts scored guesses (saturating at
//            MAX_TURNS) and registers the win / game-over flags.
// Ports    : clk, resetn   - clock, synchronous active-low reset
//            new_game      - clears all game state (priority over done_en)
//            done_en       - one-cycle strobe: a guess has just been scored
//            black_acc     - final exact-match count of that guess
//            turn          - guesses scored this game
//            win           - last scored guess was a full match
//            game_over     - win, or the turn budget is spent
// Revision : 1.0 - initial release
// ============================================================================
module mastermind_turn_tracker
  import mastermind_pkg::*;
#(
  parameter int MAX_TURNS = 10,
  parameter int TURN_W    = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              new_game,
  input  logic              done_en,
  input  logic [CNT_W-1:0]  black_acc,
  output logic [TURN_W-1:0] turn,
  output logic              win,
  output logic              game_over
);

  localparam logic [TURN_W-1:0] C_MAX_TURNS = TURN_W'(MAX_TURNS);
  localparam logic [CNT_W-1:0]  C_ALL_EXACT = CNT_W'(NUM_POS);

  logic [TURN_W-1:0] r_turn;
  logic              r_win;
  logic              r_game_over;
  logic [TURN_W-1:0] w_turn_inc;

  assign w_turn_inc = r_turn + TURN_W'(1);

  always_ff @(posedge clk) begin
    if (!resetn || new_game) begin
      r_turn      <= '0;
      r_win       <= 1'b0;
      r_game_over <= 1'b0;
    end else if (done_en) begin
      if (r_turn != C_MAX_TURNS) begin
        r_turn <= w_turn_inc;
      end
      r_win       <= (black_acc == C_ALL_EXACT);
      r_game_over <= (black_acc == C_ALL_EXACT) || (w_turn_inc == C_MAX_TURNS);
    end
  end

  assign turn      = r_turn;
  assign win       = r_win;
  assign game_over = r_game_over;

endmodule
`default_nettype wire

// File: rtl/mastermind_score_seq.sv
`default_nettype none
// ============================================================================
// Module   : mastermind_score_seq
// Purpose  : Scores a Mastermind guess against the secret code with a single
//            shared comparator: 4-cycle exact pass, 16-cycle colour pass,
//            1-cycle result cycle. Tracks turns, win and game-over.
// Ports    : clk, resetn   - clock, synchronous active-low reset
//            start         - pulse: score the current guess
//            new_game      - pulse: clear game state, abort scoring
//            code, guess   - packed 4 x COLOR_W, position i at [i*COLOR_W +: COLOR_W]
//            busy          - scoring in progress (EXACT/COLOUR/DONE)
//            done          - one-cycle pulse with fresh black/white
//            black, white  - exact / colour-only match counts
//            win, game_over, turn - game status
// Revision : 1.0 - initial release
// ============================================================================
module mastermind_score_seq
  import mastermind_pkg::*;
#(
  parameter int COLOR_W   = DEFAULT_COLOR_W,
  parameter int MAX_TURNS = 10,
  parameter int TURN_W    = 4
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       start,
  input  logic                       new_game,
  input  logic [NUM_POS*COLOR_W-1:0] code,
  input  logic [NUM_POS*COLOR_W-1:0] guess,
  output logic                       busy,
  output logic                       done,
  output logic [CNT_W-1:0]           black,
  output logic [CNT_W-1:0]           white,
  output logic                       win,
  output logic                       game_over,
  output logic [TURN_W-1:0]          turn
);

  localparam logic [MAX_COLOR_W-1:0] c_colour_mask = MAX_COLOR_W'((1 << COLOR_W) - 1);

  state_t                     r_state;
  logic [3:0]                 r_step;       // EXACT: [1:0]=idx; COLOUR: [3:2]=g, [1:0]=c
  logic [NUM_POS*COLOR_W-1:0] r_snap_code;
  logic [NUM_POS*COLOR_W-1:0] r_snap_guess;
  logic [NUM_POS-1:0]         r_code_used;
  logic [NUM_POS-1:0]         r_guess_used;
  logic [CNT_W-1:0]           r_black_acc;
  logic [CNT_W-1:0]           r_white_acc;
  logic [CNT_W-1:0]           r_black;
  logic [CNT_W-1:0]           r_white;
  logic                       r_done;
  logic                       r_busy;

  logic [1:0]             w_gi;
  logic [1:0]             w_ci;
  logic [MAX_COLOR_W-1:0] w_guess_col;
  logic [MAX_COLOR_W-1:0] w_code_col;
  logic                   w_eq;
  logic                   w_exact_hit;
  logic                   w_colour_hit;
  logic                   w_last_colour;

  // In EXACT both sides use the same position; in COLOUR the guess index is
  // the outer loop and the code index the inner loop.
  assign w_gi = (r_state == EXACT) ? r_step[1:0] : r_step[3:2];
  assign w_ci = r_step[1:0];

  assign w_guess_col = colour_at(VEC_W'(r_snap_guess), COLOR_W, w_gi);
  assign w_code_col  = colour_at(VEC_W'(r_snap_code),  COLOR_W, w_ci);
  assign w_eq        = ((w_guess_col & c_colour_mask) == (w_code_col & c_colour_mask));

  assign w_exact_hit   = (r_state == EXACT) && w_eq;
  assign w_colour_hit  = (r_state == COLOUR) && w_eq &&
                         !r_guess_used[w_gi] && !r_code_used[w_ci];
  assign w_last_colour = (r_state == COLOUR) && (r_step == 4'hF);

  always_ff @(posedge clk) begin
    if (!resetn || new_game) begin
      r_state      <= IDLE;
      r_step       <= '0;
      r_snap_code  <= '0;
      r_snap_guess <= '0;
      r_code_used  <= '0;
      r_guess_used <= '0;
      r_black_acc  <= '0;
      r_white_acc  <= '0;
      r_black      <= '0;
      r_white      <= '0;
      r_done       <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start && !game_over) begin
            r_snap_code  <= code;
            r_snap_guess <= guess;
            r_code_used  <= '0;
            r_guess_used <= '0;
            r_black_acc  <= '0;
            r_white_acc  <= '0;
            r_step       <= '0;
            r_busy       <= 1'b1;
            r_state      <= EXACT;
          end
        end
        EXACT: begin
          if (w_exact_hit) begin
            r_black_acc       <= r_black_acc + CNT_W'(1);
            r_code_used[w_ci] <= 1'b1;
            r_guess_used[w_gi] <= 1'b1;
          end
          if (r_step[1:0] == 2'd3) begin
            r_step  <= '0;
            r_state <= COLOUR;
          end else begin
            r_step <= r_step + 4'd1;
          end
        end
        COLOUR: begin
          if (w_colour_hit) begin
            r_white_acc        <= r_white_acc + CNT_W'(1);
            r_code_used[w_ci]  <= 1'b1;
            r_guess_used[w_gi] <= 1'b1;
          end
          r_step <= r_step + 4'd1;
          // Publish results on entry to DONE so they are valid alongside done;
          // the final comparison's hit is folded in here.
          if (w_last_colour) begin
            r_black <= r_black_acc;
            r_white <= r_white_acc + CNT_W'(w_colour_hit);
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  mastermind_turn_tracker #(
    .MAX_TURNS (MAX_TURNS),
    .TURN_W    (TURN_W)
  ) u_turn_tracker (
    .clk       (clk),
    .resetn    (resetn),
    .new_game  (new_game),
    .done_en   (w_last_colour),
    .black_acc (r_black_acc),
    .turn      (turn),
    .win       (win),
    .game_over (game_over)
  );

  assign busy  = r_busy;
  assign done  = r_done;
  assign black = r_black;
  assign white = r_white;

endmodule
`default_nettype wire

// File: tb/tb_mastermind_score_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_mastermind_score_seq
// Purpose  : Directed self-checking bench for mastermind_score_seq.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mastermind_score_seq;

  logic        clk;
  logic        resetn;
  logic        start;
  logic        new_game;
  logic [11:0] code;
  logic [11:0] guess;
  logic        busy;
  logic        done;
  logic [2:0]  black;
  logic [2:0]  white;
  logic        win;
  logic        game_over;
  logic [3:0]  turn;

  int checks   = 0;
  int failures = 0;

  mastermind_score_seq #(
    .COLOR_W   (3),
    .MAX_TURNS (10),
    .TURN_W    (4)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .start     (start),
    .new_game  (new_game),
    .code      (code),
    .guess     (guess),
    .busy      (busy),
    .done      (done),
    .black     (black),
    .white     (white),
    .win       (win),
    .game_over (game_over),
    .turn      (turn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] pack(input int p0, input int p1, input int p2, input int p3);
    return {3'(p3), 3'(p2), 3'(p1), 3'(p0)};
  endfunction

  // Starts one turn and waits for done. lat = cycle index of done, where the
  // cycle right after the start edge is 1; 40 means done never came.
  task automatic run_turn(input logic [11:0] c, input logic [11:0] g, output int lat);
    @(negedge clk);
    code  = c;
    guess = g;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    code  = 12'($urandom_range(0, 4095));
    guess = 12'($urandom_range(0, 4095));
    lat = 1;
    while (done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic pulse_new_game();
    @(negedge clk);
    new_game = 1'b1;
    @(negedge clk);
    new_game = 1'b0;
  endtask

  task automatic check_score(input string name, input int lat, input int eb, input int ew,
                             input int ewin, input int ego, input int eturn);
    checks++;
    if (lat !== 21) begin failures++; $display("FAIL %s latency got=%0d exp=21", name, lat); end
    checks++;
    if (black !== 3'(eb) || white !== 3'(ew)) begin
      failures++; $display("FAIL %s pegs got b=%0d w=%0d exp b=%0d w=%0d", name, black, white, eb, ew);
    end
    checks++;
    if (win !== 1'(ewin) || game_over !== 1'(ego) || turn !== 4'(eturn)) begin
      failures++; $display("FAIL %s status got win=%0b go=%0b turn=%0d exp win=%0d go=%0d turn=%0d",
                           name, win, game_over, turn, ewin, ego, eturn);
    end
  endtask

  // Pulses start and watches for any busy/done over the next cycles.
  task automatic expect_ignored_start(input string name);
    int seen_busy;
    int seen_done;
    seen_busy = 0;
    seen_done = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 25; i++) begin
      if (busy === 1'b1) seen_busy++;
      if (done === 1'b1) seen_done++;
      @(negedge clk);
    end
    checks++;
    if (seen_busy != 0 || seen_done != 0) begin
      failures++; $display("FAIL %s busy_cycles=%0d done_pulses=%0d exp 0/0", name, seen_busy, seen_done);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, done, black, white, win, game_over, turn} !== 13'd0) begin
      failures++; $display("FAIL reset outputs got busy=%0b done=%0b b=%0d w=%0d win=%0b go=%0b turn=%0d exp all 0",
                           busy, done, black, white, win, game_over, turn);
    end
  endtask

  task automatic test_exact_win();
    int lat;
    run_turn(pack(1,2,3,4), pack(1,2,3,4), lat);
    check_score("exact_win", lat, 4, 0, 1, 1, 1);
    expect_ignored_start("start_after_win");
  endtask

  task automatic test_permutation();
    int lat;
    pulse_new_game();
    run_turn(pack(1,2,3,4), pack(4,3,2,1), lat);
    check_score("permutation", lat, 0, 4, 0, 0, 1);
  endtask

  task automatic test_duplicates();
    int lat;
    pulse_new_game();
    run_turn(pack(1,1,2,2), pack(1,2,1,1), lat);
    check_score("dup_1122", lat, 1, 2, 0, 0, 1);
    run_turn(pack(5,5,5,5), pack(5,0,0,0), lat);
    check_score("dup_5555", lat, 1, 0, 0, 0, 2);
  endtask

  task automatic test_turn_limit();
    int lat;
    pulse_new_game();
    for (int t = 1; t <= 10; t++) begin
      run_turn(pack(0,0,0,0), pack(1,1,1,1), lat);
      if (t == 9) check_score("limit_turn9", lat, 0, 0, 0, 0, 9);
    end
    check_score("limit_turn10", lat, 0, 0, 0, 1, 10);
    expect_ignored_start("start_after_limit");
  endtask

  task automatic test_abort();
    int lat;
    int n;
    int seen_done;
    pulse_new_game();
    run_turn(pack(1,2,3,4), pack(1,2,4,3), lat);
    check_score("pre_abort", lat, 2, 2, 0, 0, 1);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (n < 10) begin @(negedge clk); n++; end
    new_game = 1'b1;
    @(negedge clk);
    new_game = 1'b0;
    checks++;
    if (busy !== 1'b0 || turn !== 4'd0 || black !== 3'd0 || white !== 3'd0) begin
      failures++; $display("FAIL abort_state got busy=%0b turn=%0d b=%0d w=%0d exp 0", busy, turn, black, white);
    end
    seen_done = 0;
    for (int i = 0; i < 30; i++) begin
      if (done === 1'b1) seen_done++;
      @(negedge clk);
    end
    checks++;
    if (seen_done != 0 || turn !== 4'd0) begin
      failures++; $display("FAIL abort_no_done got done_pulses=%0d turn=%0d exp 0/0", seen_done, turn);
    end
  endtask

  task automatic test_start_while_busy();
    int seen_done;
    pulse_new_game();
    @(negedge clk);
    code  = pack(1,2,3,4);
    guess = pack(1,2,3,5);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen_done = 0;
    for (int n = 1; n < 60; n++) begin
      // Extra starts mid-EXACT, mid-COLOUR and in the DONE cycle.
      start = (n == 3 || n == 12 || done === 1'b1);
      if (done === 1'b1) seen_done++;
      @(negedge clk);
      start = 1'b0;
    end
    checks++;
    if (seen_done != 1 || turn !== 4'd1 || black !== 3'd3 || white !== 3'd0) begin
      failures++; $display("FAIL start_while_busy got dones=%0d turn=%0d b=%0d w=%0d exp 1/1/3/0",
                           seen_done, turn, black, white);
    end
  endtask

  task automatic test_same_cycle();
    int seen_busy;
    pulse_new_game();
    @(negedge clk);
    new_game = 1'b1;
    start    = 1'b1;
    @(negedge clk);
    new_game = 1'b0;
    start    = 1'b0;
    seen_busy = 0;
    for (int i = 0; i < 25; i++) begin
      if (busy === 1'b1 || done === 1'b1) seen_busy++;
      @(negedge clk);
    end
    checks++;
    if (seen_busy != 0 || turn !== 4'd0) begin
      failures++; $display("FAIL same_cycle_drop got active_cycles=%0d turn=%0d exp 0/0", seen_busy, turn);
    end
  endtask

  task automatic test_reset_mid_colour();
    int lat;
    int seen_done;
    pulse_new_game();
    run_turn(pack(1,2,3,4), pack(1,2,3,4), lat);
    check_score("pre_reset_win", lat, 4, 0, 1, 1, 1);
    pulse_new_game();
    run_turn(pack(1,2,3,4), pack(4,3,2,1), lat);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 1; n < 12; n++) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    checks++;
    if ({busy, done, black, white, win, game_over, turn} !== 13'd0) begin
      failures++; $display("FAIL reset_mid_colour got busy=%0b done=%0b b=%0d w=%0d win=%0b go=%0b turn=%0d exp all 0",
                           busy, done, black, white, win, game_over, turn);
    end
    seen_done = 0;
    for (int i = 0; i < 25; i++) begin
      if (done === 1'b1) seen_done++;
      @(negedge clk);
    end
    checks++;
    if (seen_done != 0) begin
      failures++; $display("FAIL reset_no_done got done_pulses=%0d exp 0", seen_done);
    end
    run_turn(pack(1,2,3,4), pack(1,2,4,3), lat);
    check_score("after_reset", lat, 2, 2, 0, 0, 1);
  endtask

  initial begin
    resetn   = 1'b0;
    start    = 1'b0;
    new_game = 1'b0;
    code     = '0;
    guess    = '0;
    test_reset();
    test_exact_win();
    test_permutation();
    test_duplicates();
    test_turn_limit();
    test_abort();
    test_start_while_busy();
    test_same_cycle();
    test_reset_mid_colour();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
